apu_frame_sequencer: RTL

Frame sequencer (LFO generator) of the 2A03 APU. Sits directly upstream of the envelope, length and sweep units and drives their quarter-frame strobe (n_LFO1) and half-frame strobe (n_LFO2). It also raises the frame IRQ.
It counts APU cycles (ACLK1 enables), is configured by writes to the $4017 register, and is cleared by reads of the status register.

---
 rtl/apu_frame_sequencer.sv | 114 +++++++++++
 1 files changed

// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: counts ACLK1 enables and emits quarter/half-frame strobes and the frame IRQ.
// Build option APU_FAST_LFO_EN scales every step comparison down by 64 for short simulation runs.
module apu_frame_sequencer #(
    parameter int STEP1 = 3728,
    parameter int STEP2 = 7456,
    parameter int STEP3 = 11185,
    parameter int STEP4 = 14914,
    parameter int STEP5 = 18640
) (
    input  logic       CLK,
    input  logic       n_RES,
    input  logic       ACLK1,
    input  logic       WR_Reg,
    input  logic       RD_Status,
    input  logic [7:0] DB,
    output logic       n_LFO1,
    output logic       n_LFO2,
    output logic       FrameIRQ,
    output logic       n_IRQ
);

`ifdef APU_FAST_LFO_EN
    localparam int SHIFT = 6;
`else
    localparam int SHIFT = 0;
`endif

    localparam logic [14:0] C1 = 15'(STEP1 >> SHIFT);
    localparam logic [14:0] C2 = 15'(STEP2 >> SHIFT);
    localparam logic [14:0] C3 = 15'(STEP3 >> SHIFT);
    localparam logic [14:0] C4 = 15'(STEP4 >> SHIFT);
    localparam logic [14:0] C5 = 15'(STEP5 >> SHIFT);

    // RS_WAIT: write seen, waiting for the arming ACLK1; RS_ARMED: next ACLK1 resets the counter
    typedef enum logic [1:0] {RS_IDLE, RS_WAIT, RS_ARMED} rs_t;

    rs_t         rs, rs_nxt;
    logic        do_rst;
    logic [14:0] cnt;
    logic [14:0] last;
    logic        mode, inhibit, irq;
    logic        lfo1_q, lfo2_q;
    logic        step_ok, q_stb, h_stb, irq_set;

    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES) rs <= RS_IDLE;
        else        rs <= rs_nxt;
    end

    // A write in the same cycle as an ACLK1 restarts the delay; that ACLK1 never counts toward it
    always_comb begin
        rs_nxt = rs;
        do_rst = 1'b0;
        if (WR_Reg) begin
            rs_nxt = RS_WAIT;
        end else if (ACLK1) begin
            case (rs)
                RS_WAIT:  rs_nxt = RS_ARMED;
                RS_ARMED: begin
                    rs_nxt = RS_IDLE;
                    do_rst = 1'b1;
                end
                default:  rs_nxt = rs;
            endcase
        end
    end

    // Decode uses the registered mode, so a write in a step cycle still sees the old mode
    always_comb begin
        last    = mode ? C5 : C4;
        step_ok = ACLK1 && !do_rst;
        q_stb   = step_ok && (cnt == C1 || cnt == C2 || cnt == C3 || cnt == last);
        h_stb   = step_ok && (cnt == C2 || cnt == last);
        irq_set = step_ok && !mode && !inhibit && (cnt == C4);
    end

    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES) begin
            cnt     <= '0;
            mode    <= 1'b0;
            inhibit <= 1'b0;
            irq     <= 1'b0;
            lfo1_q  <= 1'b0;
            lfo2_q  <= 1'b0;
        end else begin
            if (do_rst)
                cnt <= '0;
            else if (ACLK1)
                cnt <= (cnt == last) ? 15'd0 : cnt + 15'd1;

            lfo1_q <= q_stb || (do_rst && mode);
            lfo2_q <= h_stb || (do_rst && mode);

            if (WR_Reg) begin
                mode    <= DB[7];
                inhibit <= DB[6];
            end

            // Set beats a status read; an inhibiting write beats both
            if (WR_Reg && DB[6])
                irq <= 1'b0;
            else if (irq_set)
                irq <= 1'b1;
            else if (RD_Status)
                irq <= 1'b0;
        end
    end

    assign n_LFO1   = ~lfo1_q;
    assign n_LFO2   = ~lfo2_q;
    assign FrameIRQ = irq;
    assign n_IRQ    = ~irq;

endmodule
